// File: rtl/mux_pkg.sv
// Shared constants and types for the registered 8-to-1 mux.
// Select width and input count used by mux_8x1 and its bench.
package mux_pkg;

    localparam int SEL_W = 3;
    localparam int N_IN  = 8;

    typedef logic [SEL_W-1:0] sel_t;

endpackage

// File: rtl/mux2x1.sv
// 2-to-1 mux leaf used to build the 8-to-1 select tree.
// y = s ? b : a.
module mux2x1 #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             s,
    output logic [WIDTH-1:0] y
);

    assign y = s ? b : a;

endmodule

// File: rtl/mux_8x1.sv
// Registered 8-to-1 mux built as a three-level tree of mux2x1.
// Define MUX8X1_INREG_EN to add an input register stage (latency 2).
module mux_8x1
    import mux_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d7,
    input  logic [WIDTH-1:0] d6,
    input  logic [WIDTH-1:0] d5,
    input  logic [WIDTH-1:0] d4,
    input  logic [WIDTH-1:0] d3,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d0,
    input  logic             s0,
    input  logic             s1,
    input  logic             s2,
    output logic [WIDTH-1:0] y
);

    logic [WIDTH-1:0] d_raw [N_IN];
    logic [WIDTH-1:0] d_m   [N_IN];
    sel_t             sel_raw;
    sel_t             sel_m;

    logic [WIDTH-1:0] l1 [4];
    logic [WIDTH-1:0] l2 [2];
    logic [WIDTH-1:0] mux_y;

    assign sel_raw = {s2, s1, s0};
    assign d_raw   = '{d0, d1, d2, d3, d4, d5, d6, d7};

`ifdef MUX8X1_INREG_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel_m <= '0;
            for (int i = 0; i < N_IN; i++) begin
                d_m[i] <= '0;
            end
        end else if (en) begin
            sel_m <= sel_raw;
            for (int i = 0; i < N_IN; i++) begin
                d_m[i] <= d_raw[i];
            end
        end
    end
`else
    assign sel_m = sel_raw;
    assign d_m   = d_raw;
`endif

    // Level 1 pairs (d1,d0)..(d7,d6) on s0, then s1, then s2.
    for (genvar i = 0; i < 4; i++) begin : g_l1
        mux2x1 #(.WIDTH(WIDTH)) u_mux (
            .a (d_m[2*i]),
            .b (d_m[2*i+1]),
            .s (sel_m[0]),
            .y (l1[i])
        );
    end

    for (genvar i = 0; i < 2; i++) begin : g_l2
        mux2x1 #(.WIDTH(WIDTH)) u_mux (
            .a (l1[2*i]),
            .b (l1[2*i+1]),
            .s (sel_m[1]),
            .y (l2[i])
        );
    end

    mux2x1 #(.WIDTH(WIDTH)) u_l3 (
        .a (l2[0]),
        .b (l2[1]),
        .s (sel_m[2]),
        .y (mux_y)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y <= '0;
        end else if (en) begin
            y <= mux_y;
        end
    end

endmodule

// File: tb/tb_mux_8x1.sv
// Scoreboard bench for mux_8x1 at WIDTH 1 and WIDTH 8.
// Expected values come from a behavioural index model.
module tb_mux_8x1;
    import mux_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       s0, s1, s2;
    logic       d1 [N_IN];
    logic [7:0] d8 [N_IN];
    logic       y1;
    logic [7:0] y8;

    always #5 clk = ~clk;

    mux_8x1 #(.WIDTH(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .d7    (d1[7]),
        .d6    (d1[6]),
        .d5    (d1[5]),
        .d4    (d1[4]),
        .d3    (d1[3]),
        .d2    (d1[2]),
        .d1    (d1[1]),
        .d0    (d1[0]),
        .s0    (s0),
        .s1    (s1),
        .s2    (s2),
        .y     (y1)
    );

    mux_8x1 #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .d7    (d8[7]),
        .d6    (d8[6]),
        .d5    (d8[5]),
        .d4    (d8[4]),
        .d3    (d8[3]),
        .d2    (d8[2]),
        .d1    (d8[1]),
        .d0    (d8[0]),
        .s0    (s0),
        .s1    (s1),
        .s2    (s2),
        .y     (y8)
    );

    typedef struct packed {
        logic       y1;
        logic [7:0] y8;
    } exp_t;

    exp_t       exp_q [$];
    logic       m_y1;
    logic [7:0] m_y8;
    logic       m_d1 [N_IN];
    logic [7:0] m_d8 [N_IN];
    sel_t       m_sel;
    int         checks = 0;
    int         errors = 0;

    task automatic check(string tag, logic [7:0] got, logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic set_sel(int k);
        {s2, s1, s0} = 3'(k);
    endtask

    task automatic set_d1(logic [7:0] v);
        for (int k = 0; k < N_IN; k++) d1[k] = v[k];
    endtask

    task automatic rand_d8();
        for (int k = 0; k < N_IN; k++) d8[k] = 8'($urandom);
    endtask

    // Advance the model for the coming edge, push, clock, pop, compare.
    task automatic step(string tag);
        exp_t e;
        sel_t cs;
        cs = {s2, s1, s0};
        if (!rst_n) begin
            m_y1 = 1'b0;
            m_y8 = 8'h00;
`ifdef MUX8X1_INREG_EN
            m_sel = '0;
            for (int k = 0; k < N_IN; k++) begin
                m_d1[k] = 1'b0;
                m_d8[k] = 8'h00;
            end
`endif
        end else if (en) begin
`ifdef MUX8X1_INREG_EN
            m_y1  = m_d1[m_sel];
            m_y8  = m_d8[m_sel];
            m_sel = cs;
            for (int k = 0; k < N_IN; k++) begin
                m_d1[k] = d1[k];
                m_d8[k] = d8[k];
            end
`else
            m_y1 = d1[cs];
            m_y8 = d8[cs];
`endif
        end
        e.y1 = m_y1;
        e.y8 = m_y8;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check({tag, "/w1"}, {7'b0, y1}, {7'b0, e.y1});
        check({tag, "/w8"}, y8, e.y8);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout checks %0d", checks);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        en    = 1'b1;
        set_d1(8'hFF);
        rand_d8();
        set_sel(7);
        #2;
        step("rst");
        step("rst");
        rst_n = 1'b1;
        step("rel");
        step("rel");

        for (int hot = 0; hot < N_IN; hot++) begin
            set_d1(8'h01 << hot);
            for (int s = 0; s < N_IN; s++) begin
                set_sel(s);
                rand_d8();
                step("walk");
            end
        end

        set_d1(8'b0001_0001); set_sel(2); step("mix_d2");
        set_d1(8'b0111_0111); set_sel(0); step("mix_d0");
        set_d1(8'b0101_0101); set_sel(3); step("mix_d3");
        set_d1(8'b0100_0100); set_sel(6); step("mix_d6");
        step("mix_d6b");

        set_d1(8'hFF); set_sel(0); step("hold_pre"); step("hold_pre");
        en = 1'b0;
        set_d1(8'h00); set_sel(5); rand_d8();
        step("hold"); step("hold"); step("hold");
        en = 1'b1;
        step("hold_rel"); step("hold_rel");

        for (int i = 0; i < 20; i++) begin
            en = 1'($urandom);
            set_d1(8'($urandom));
            rand_d8();
            set_sel(int'($urandom_range(0, 7)));
            step("stream");
        end
        rst_n = 1'b0;
        en    = 1'b0;
        set_d1(8'hFF);
        rand_d8();
        step("mid_rst");
        rst_n = 1'b1;
        en    = 1'b1;
        step("mid_rel");
        step("mid_rel");

        for (int k = 0; k < N_IN; k++) d8[k] = 8'h10 + 8'(k);
        for (int s = 0; s < N_IN; s++) begin
            set_sel(s);
            set_d1(8'($urandom));
            step("w8_sweep");
        end
        step("w8_tail");

        for (int i = 0; i < 40; i++) begin
            rst_n = ($urandom_range(0, 9) != 0);
            en    = 1'($urandom);
            set_d1(8'($urandom));
            rand_d8();
            set_sel(int'($urandom_range(0, 7)));
            step("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
